// File: rtl/status_line_writer.sv
// DSM status line writer: sweeps N_LINES snapshot cache lines into device status
// memory through the shared Tx1 write arbiter, with resweep-on-request and optional refresh.
module status_line_writer #(
    parameter int N_LINES         = 4,
    parameter int ADDR_W          = 32,
    parameter int DSM_LINE_OFFSET = 0,
    parameter int REFRESH_CYCLES  = 0
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [ADDR_W-1:0]      dsm_base,
    input  logic                   dsm_base_valid,
    input  logic [N_LINES*512-1:0] status_data,
    input  logic                   update_req,
    output logic                   wr_request,
    output logic [ADDR_W-1:0]      wr_line_addr,
    output logic [511:0]           wr_data,
    input  logic                   wr_grant,
    output logic                   sweep_done,
    output logic                   busy,
    output logic [15:0]            sweep_count,
    output logic [1:0]             state_dbg
);

    // Handshake: wr_request is a level; a line is consumed on any cycle where
    // wr_request && wr_grant. wr_line_addr/wr_data stay stable until that cycle.

    localparam int IDX_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic                   pending, pending_nxt;
    logic [CNT_W-1:0]       refresh_cnt, refresh_cnt_nxt;
    logic [15:0]            sweep_count_nxt;
    logic [N_LINES*512-1:0] snapshot;
    logic                   take_snapshot;
    logic                   last_line;
    logic                   refresh_hit;

    assign busy       = (state == ST_WRITE);
    assign wr_request = busy && dsm_base_valid;
    assign last_line  = (idx == IDX_W'(N_LINES - 1));
    assign state_dbg  = state;

    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            assign refresh_hit = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));
        end else begin : g_no_refresh
            assign refresh_hit = 1'b0;
        end
    endgenerate

    // Address and payload are forced to zero outside a sweep so reset and idle read clean.
    assign wr_line_addr = busy ? (dsm_base + ADDR_W'(DSM_LINE_OFFSET) + ADDR_W'(idx))
                               : '0;
    assign wr_data      = busy ? snapshot[32'(idx)*512 +: 512] : '0;

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        pending_nxt     = pending;
        refresh_cnt_nxt = '0;
        sweep_count_nxt = sweep_count;
        take_snapshot   = 1'b0;
        sweep_done      = 1'b0;

        if (!dsm_base_valid) begin
            state_nxt   = ST_IDLE;
            idx_nxt     = '0;
            pending_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt     = ST_WRITE;
                    idx_nxt       = '0;
                    take_snapshot = 1'b1;
                end
                ST_WRITE: begin
                    pending_nxt = pending | update_req;
                    if (wr_grant) begin
                        if (!last_line) begin
                            idx_nxt = idx + 1'b1;
                        end else begin
                            sweep_done      = 1'b1;
                            sweep_count_nxt = sweep_count + 16'd1;
                            idx_nxt         = '0;
                            // A request landing on the last grant still counts.
                            if (pending || update_req) begin
                                state_nxt     = ST_WRITE;
                                take_snapshot = 1'b1;
                                pending_nxt   = 1'b0;
                            end else begin
                                state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (pending || update_req || refresh_hit) begin
                        state_nxt     = ST_WRITE;
                        idx_nxt       = '0;
                        take_snapshot = 1'b1;
                        pending_nxt   = 1'b0;
                    end else begin
                        refresh_cnt_nxt = refresh_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    idx_nxt     = '0;
                    pending_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            refresh_cnt <= '0;
            sweep_count <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            pending     <= pending_nxt;
            refresh_cnt <= refresh_cnt_nxt;
            sweep_count <= sweep_count_nxt;
        end
    end

    // Snapshot is pure data; wr_data is gated while idle, so it needs no reset.
    always_ff @(posedge clk) begin
        if (take_snapshot) begin
            snapshot <= status_data;
        end
    end

endmodule
